// File: rtl/dtree_seq_eval.sv
// Table-driven decision-tree classifier: captures a feature vector, walks one
// node per clock through a loadable node table and returns the leaf class.
module dtree_seq_eval #(
    parameter int unsigned N_FEAT    = 5,
    parameter int unsigned FEAT_W    = 8,
    parameter int unsigned N_NODES   = 64,
    parameter int unsigned MAX_DEPTH = 16,
    parameter int unsigned CLASS_W   = 6,
    localparam int unsigned ADDR_W   = $clog2(N_NODES),
    localparam int unsigned FIDX_W   = $clog2(N_FEAT),
    localparam int unsigned SH_W     = $clog2(FEAT_W),
    localparam int unsigned NODE_W   = 1 + FIDX_W + SH_W + FEAT_W + 2 * ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [ADDR_W-1:0]          cfg_addr,
    input  logic [NODE_W-1:0]          cfg_data,
    output logic                       cfg_err,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_FEAT*FEAT_W-1:0]   in_feat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CLASS_W-1:0]         out_class,
    output logic                       out_err
);

    localparam int unsigned STEP_W = $clog2(MAX_DEPTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WALK = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [NODE_W-1:0]          table_q [N_NODES];
    logic [1:0]                 state, state_nxt;
    logic [ADDR_W-1:0]          ptr, ptr_nxt;
    logic [STEP_W-1:0]          steps, steps_nxt;
    logic [N_FEAT*FEAT_W-1:0]   feat_q, feat_nxt;
    logic [CLASS_W-1:0]         class_nxt;
    logic                       err_nxt;

    logic [NODE_W-1:0]          node;
    logic                       n_leaf;
    logic [FIDX_W-1:0]          n_fidx;
    logic [SH_W-1:0]            n_shift;
    logic [FEAT_W-1:0]          n_thr;
    logic [ADDR_W-1:0]          n_left, n_right, child;
    logic [FEAT_W-1:0]          sel;
    logic                       cond, child_bad, depth_hit, table_wr;

    // Node decode: leaf | fidx | shift | thr | left | right
    assign node      = table_q[ptr];
    assign n_leaf    = node[NODE_W-1];
    assign n_fidx    = node[NODE_W-2 -: FIDX_W];
    assign n_shift   = node[NODE_W-2-FIDX_W -: SH_W];
    assign n_thr     = node[2*ADDR_W +: FEAT_W];
    assign n_left    = node[ADDR_W +: ADDR_W];
    assign n_right   = node[0 +: ADDR_W];

    // Out-of-range feature indices fall back to feature 0
    always_comb begin
        sel = feat_q[FEAT_W-1:0];
        for (int unsigned f = 1; f < N_FEAT; f++) begin
            if (n_fidx == FIDX_W'(f)) sel = feat_q[f*FEAT_W +: FEAT_W];
        end
    end

    assign cond      = (sel >> n_shift) <= n_thr;
    assign child     = cond ? n_left : n_right;
    assign child_bad = {1'b0, child} >= (ADDR_W+1)'(N_NODES);
    assign depth_hit = steps == STEP_W'(MAX_DEPTH);
    assign table_wr  = cfg_we && (state == IDLE) &&
                       ({1'b0, cfg_addr} < (ADDR_W+1)'(N_NODES));

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        steps_nxt = steps;
        feat_nxt  = feat_q;
        class_nxt = out_class;
        err_nxt   = out_err;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    feat_nxt  = in_feat;
                    ptr_nxt   = '0;
                    steps_nxt = '0;
                    state_nxt = WALK;
                end
            end
            WALK: begin
                if (n_leaf) begin
                    class_nxt = n_thr[CLASS_W-1:0];
                    err_nxt   = 1'b0;
                    state_nxt = DONE;
                end else if (child_bad || depth_hit) begin
                    class_nxt = '0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    ptr_nxt   = child;
                    steps_nxt = steps + STEP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            steps     <= '0;
            feat_q    <= '0;
            out_class <= '0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            steps     <= steps_nxt;
            feat_q    <= feat_nxt;
            out_class <= class_nxt;
            out_err   <= err_nxt;
            in_ready  <= state_nxt == IDLE;
            out_valid <= state_nxt == DONE;
            if (cfg_we && state != IDLE) cfg_err <= 1'b1;
        end
    end

    // Table survives reset; writes land only while idle
    always_ff @(posedge clk) begin
        if (table_wr) table_q[cfg_addr] <= cfg_data;
    end

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Directed bench for dtree_seq_eval: hand-built trees with hand-computed
// classes and latencies.
module tb_dtree_seq_eval;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [26:0] cfg_data;
    logic        cfg_err;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] in_feat;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_class;
    logic        out_err;

    int checks = 0;
    int failures = 0;

    dtree_seq_eval dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic logic [26:0] nd(input logic leaf, input int fidx, input int shift,
                                       input int thr, input int l, input int r);
        return {leaf, 3'(fidx), 3'(shift), 8'(thr), 6'(l), 6'(r)};
    endfunction

    function automatic logic [39:0] fv(input int x0, input int x1, input int x2,
                                       input int x3, input int x4);
        return {8'(x4), 8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    endfunction

    // All tasks start and end 1 time unit after a rising edge
    task automatic cfg_write(input int a, input logic [26:0] d);
        cfg_we = 1'b1; cfg_addr = 6'(a); cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic start_vec(input logic [39:0] f);
        in_valid = 1'b1; in_feat = f;
        @(posedge clk); #1;
        in_valid = 1'b0; in_feat = ~f;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [39:0] f, input int exp_cls,
                       input int exp_err, input int exp_lat);
        int lat;
        start_vec(f);
        wait_out(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_class"}, 32'(out_class), exp_cls);
        check({tag, "_err"}, 32'(out_err), exp_err);
        ack();
        check({tag, "_in_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        int lat;
        logic seen;
        logic stable;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_class", 32'(out_class), 0);
        check("rst_out_err", 32'(out_err), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);

        cfg_write(0, nd(1, 0, 0, 42, 0, 0));
        run("root_leaf", fv(1, 2, 3, 4, 5), 42, 0, 1);

        // Two-level tree: X0>>1 <= 10 ? leaf 3 : leaf 7
        cfg_write(0, nd(0, 0, 1, 10, 1, 2));
        cfg_write(1, nd(1, 0, 0, 3, 0, 0));
        cfg_write(2, nd(1, 0, 0, 7, 0, 0));
        run("two_lvl_21", fv(21, 0, 0, 0, 0), 3, 0, 2);
        run("two_lvl_22", fv(22, 0, 0, 0, 0), 7, 0, 2);

        // Backpressure: result held, no new input accepted
        start_vec(fv(22, 0, 0, 0, 0));
        wait_out(lat);
        check("bp_lat", lat, 2);
        stable = 1'b1; seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!out_valid || out_class !== 6'd7) stable = 1'b0;
            if (in_ready) seen = 1'b1;
        end
        check("bp_stable", 32'(stable), 1);
        check("bp_in_ready_low", 32'(seen), 0);
        ack();
        check("bp_in_ready_after", 32'(in_ready), 1);

        // Write during WALK is dropped and flagged
        start_vec(fv(21, 0, 0, 0, 0));
        cfg_write(1, nd(1, 0, 0, 9, 0, 0));
        wait_out(lat);
        check("guard_class", 32'(out_class), 3);
        check("guard_cfg_err", 32'(cfg_err), 1);
        ack();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("guard_rst_cfg_err", 32'(cfg_err), 0);
        run("guard_retained", fv(21, 0, 0, 0, 0), 3, 0, 2);

        // fidx beyond N_FEAT reads feature 0; precision-truncated compare on feature 3
        cfg_write(0, nd(0, 7, 0, 50, 1, 2));
        run("fidx_oob", fv(40, 200, 200, 200, 200), 3, 0, 2);
        cfg_write(0, nd(0, 3, 3, 16, 1, 2));
        run("shift_135", fv(0, 0, 0, 135, 0), 3, 0, 2);
        run("shift_136", fv(0, 0, 0, 136, 0), 7, 0, 2);

        // Write concurrent with accept is seen by the walk
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = nd(1, 0, 0, 11, 0, 0);
        in_valid = 1'b1; in_feat = fv(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        wait_out(lat);
        check("wr_accept_lat", lat, 1);
        check("wr_accept_class", 32'(out_class), 11);
        ack();

        // Self-loop: abort at depth limit
        cfg_write(0, nd(0, 0, 0, 0, 0, 0));
        run("abort", fv(5, 0, 0, 0, 0), 0, 1, 17);

        // Depth-5 chain 0->3->4->5->6->7(leaf 33)
        cfg_write(0, nd(0, 0, 0, 255, 3, 3));
        cfg_write(3, nd(0, 1, 0, 255, 4, 4));
        cfg_write(4, nd(0, 2, 0, 255, 5, 5));
        cfg_write(5, nd(0, 3, 0, 255, 6, 6));
        cfg_write(6, nd(0, 4, 0, 255, 7, 7));
        cfg_write(7, nd(1, 0, 0, 33, 0, 0));
        run("chain", fv(9, 8, 7, 6, 5), 33, 0, 6);

        // Reset during walk cycle 2 discards the result
        start_vec(fv(9, 8, 7, 6, 5));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = out_valid;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", 32'(seen), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        run("midrst_next", fv(1, 1, 1, 1, 1), 33, 0, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
